dpi_stream_sequencer: RTL and testbench
=======================================

Name: dpi_stream_sequencer

Overview:
- Front-end controller for a bank of NUM_CAT per-category regex matcher wrappers that share one 64-stream state memory scheme.
- Accepts a byte-wide packet stream tagged with a 6-bit stream id and sequences each packet through the wrappers: load_state, settle, chars, drain, eop.
- Tracks first-seen streams and drives new_stream_id.
- Holds the per-stream category enable table and reports a per-packet hit vector.

Parameters:
- NUM_CAT, 8, number of matcher wrappers driven in parallel (1..32).
- DRAIN_CYC, 2, idle cycles between the last char and the eop pulse, covering matcher accept latency (1..7).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- pkt_vld  in  1  input beat valid
- pkt_rdy  out  1  input beat accepted when pkt_vld & pkt_rdy
- pkt_data  in  8  packet byte
- pkt_sop  in  1  first beat of packet
- pkt_eop  in  1  last beat of packet
- pkt_sid  in  6  stream id; sampled on the SOP beat only
- cfg_we  in  1  write enable-table entry
- cfg_sid  in  6  table address
- cfg_en_mask  in  NUM_CAT  category enables for cfg_sid
- cfg_clr_seen  in  1  clear the seen bit of cfg_sid
- m_load_state  out  1  load/restore pulse to wrappers
- m_new_stream_id  out  1  stream not yet seen; wrappers zero state
- m_stream_id  out  6  current stream id
- m_char_in  out  8  byte to matchers
- m_char_in_vld  out  1  byte valid
- m_eop  out  1  end-of-packet pulse
- m_enable  out  NUM_CAT  per-category enable, valid with m_eop
- m_fired  in  NUM_CAT  per-wrapper fired flags
- res_vld  out  1  one-cycle result pulse
- res_sid  out  6  stream id of result
- res_hits  out  NUM_CAT  m_fired & m_enable captured at eop
- pkt_cnt  out  16  packets completed, wraps
- drop_cnt  out  16  beats dropped outside a packet, wraps

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; seen bitmap and enable table cleared; all outputs and counters 0. Reset mid-packet abandons the packet with no eop and no result.
- FSM: IDLE, LOAD, SETTLE, STREAM, DRAIN, EOP, REPORT.
- IDLE:
  - pkt_vld & pkt_sop: pkt_rdy=0 (beat held); latch sid, en_lat=enable_table[sid], nsid=~seen[sid]; go LOAD.
  - pkt_vld & ~pkt_sop: pkt_rdy=1, beat dropped, drop_cnt++.
- LOAD (1 cycle): m_load_state=1, m_new_stream_id=nsid, m_stream_id=sid; set seen[sid]. Go SETTLE.
- SETTLE (1 cycle): no chars; lets wrappers register and apply the restored state. Go STREAM.
- STREAM:
  - pkt_rdy=1; m_char_in=pkt_data and m_char_in_vld=pkt_vld, combinational.
  - The held SOP beat is the first char.
  - pkt_sop on a non-first beat is treated as data.
  - Accepted beat with pkt_eop: go DRAIN. A single-beat packet (sop&eop) is legal.
- DRAIN: pkt_rdy=0; count DRAIN_CYC cycles, then go EOP.
- EOP (1 cycle): m_eop=1, m_enable=en_lat; capture res_hits=m_fired&en_lat. Go REPORT.
- REPORT (1 cycle): res_vld=1, res_sid=sid; pkt_cnt++. Go IDLE.
- m_stream_id is held stable LOAD..EOP. m_enable is 0 outside EOP.
- Latency: SOP presented at cycle 0 → m_load_state at 1 → first char at 3. Last char at t → m_eop at t+1+DRAIN_CYC → res_vld one cycle later. Minimum packet-to-packet gap in IDLE is 1 cycle.
- Config:
  - cfg_we writes enable_table[cfg_sid] at any time; it takes effect at the next LOAD of that sid, because the current packet uses en_lat.
  - cfg_clr_seen clears seen[cfg_sid] at any time.
  - If cfg_clr_seen targets the sid being set in LOAD in the same cycle, the set wins.
  - cfg_we and cfg_clr_seen may coincide; both apply.
- Counters wrap 0xFFFF→0 silently.

Decomposition:
- Shared package dpi_pkg:
  - SID_W=6, NUM_STREAMS=64, CHAR_W=8.
  - FSM state encoding constants.
  - Default NUM_CAT.
- One sub-module, dpi_stream_table: seen bitmap plus enable table, with a read port on pkt_sid, a write/clear port, and the LOAD set port. The FSM stays in the top module.

Test Plan:
- Reset, then cfg_we sid=5 mask=0x03; send a 4-byte packet on sid 5 with m_fired=0x01 held → m_load_state with m_new_stream_id=1, first char 3 cycles after SOP, m_eop with m_enable=0x03, res_hits=0x01, res_sid=5, pkt_cnt=1.
- A second packet on sid 5 → m_new_stream_id=0. Then cfg_clr_seen sid 5 and a third packet → m_new_stream_id=1.
- A single-beat packet (sop&eop) on sid 63, DRAIN_CYC=2 → m_eop exactly 3 cycles after the accepted beat, res_vld on the next cycle.
- 3 beats without SOP in IDLE → pkt_rdy=1, no m_char_in_vld, drop_cnt=3.
- cfg_we sid=7 mask=0xFF issued mid-packet on sid 7 (old mask 0x00) → this packet has m_enable=0x00 and res_hits=0x00; the next packet has m_enable=0xFF.
- rst_n asserted during STREAM → all outputs 0 immediately; after release, a SOP on the same sid gives m_new_stream_id=1.

Source files
------------

// File: rtl/dpi_pkg.sv
// -----------------------------------------------------------------------------
// dpi_pkg
// Shared constants and types for the DPI stream sequencer slice.
//   SID_W, NUM_STREAMS : stream id width and number of tracked streams
//   CHAR_W             : width of a packet byte / matcher character
//   CNT_W              : width of the wrapping statistics counters
//   DEFAULT_NUM_CAT    : default number of category matcher wrappers
//   seq_state_e        : sequencer FSM state encoding
// -----------------------------------------------------------------------------
package dpi_pkg;

    localparam int SID_W           = 6;
    localparam int NUM_STREAMS     = 64;
    localparam int CHAR_W          = 8;
    localparam int CNT_W           = 16;
    localparam int DEFAULT_NUM_CAT = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_EOP    = 3'd5,
        ST_REPORT = 3'd6
    } seq_state_e;

endpackage : dpi_pkg

// File: rtl/dpi_stream_table.sv
// -----------------------------------------------------------------------------
// dpi_stream_table
// Per-stream bookkeeping: a seen bitmap and a category enable table, one entry
// per stream id.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears both tables)
//   rd_sid              combinational read address
//   rd_en_mask, rd_seen enable mask and seen bit of rd_sid
//   wr_en/wr_sid/wr_mask  enable-table write port
//   clr_en/clr_sid      clear one seen bit
//   set_en/set_sid      set one seen bit (the stream being loaded)
// -----------------------------------------------------------------------------
module dpi_stream_table
    import dpi_pkg::*;
#(
    parameter int NUM_CAT = DEFAULT_NUM_CAT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [NUM_CAT-1:0] rd_en_mask,
    output logic               rd_seen,
    input  logic               wr_en,
    input  logic [SID_W-1:0]   wr_sid,
    input  logic [NUM_CAT-1:0] wr_mask,
    input  logic               clr_en,
    input  logic [SID_W-1:0]   clr_sid,
    input  logic               set_en,
    input  logic [SID_W-1:0]   set_sid
);

    logic [NUM_STREAMS-1:0] seen_q;
    logic [NUM_CAT-1:0]     en_tbl_q [NUM_STREAMS];

    // The set is written after the clear so that a clear aimed at the
    // stream being loaded in the same cycle loses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
        end else begin
            if (clr_en) seen_q[clr_sid] <= 1'b0;
            if (set_en) seen_q[set_sid] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STREAMS; i++) en_tbl_q[i] <= '0;
        end else if (wr_en) begin
            en_tbl_q[wr_sid] <= wr_mask;
        end
    end

    assign rd_en_mask = en_tbl_q[rd_sid];
    assign rd_seen    = seen_q[rd_sid];

endmodule : dpi_stream_table

// File: rtl/dpi_stream_sequencer.sv
// -----------------------------------------------------------------------------
// dpi_stream_sequencer
// Front end for a bank of NUM_CAT per-category regex matcher wrappers. Each
// packet is walked through load_state -> settle -> chars -> drain -> eop, and
// a per-packet hit vector is reported.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   pkt_*                   byte stream input (valid/ready), sid on SOP only
//   cfg_*                   enable-table write and seen-bit clear
//   m_*                     matcher wrapper interface (m_fired is an input)
//   res_vld/res_sid/res_hits  one-cycle per-packet result
//   pkt_cnt, drop_cnt       wrapping statistics
//
// Handshake: a beat transfers on a cycle where pkt_vld & pkt_rdy are both 1.
// The source holds pkt_data/sop/eop/sid stable while pkt_vld=1 and pkt_rdy=0.
// pkt_rdy depends combinationally on pkt_vld/pkt_sop only in IDLE, where an
// SOP beat is held (rdy=0) until the stream state has been loaded, and a
// non-SOP beat is accepted and discarded.
// -----------------------------------------------------------------------------
module dpi_stream_sequencer
    import dpi_pkg::*;
#(
    parameter int NUM_CAT   = DEFAULT_NUM_CAT,
    parameter int DRAIN_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_vld,
    output logic               pkt_rdy,
    input  logic [CHAR_W-1:0]  pkt_data,
    input  logic               pkt_sop,
    input  logic               pkt_eop,
    input  logic [SID_W-1:0]   pkt_sid,
    input  logic               cfg_we,
    input  logic [SID_W-1:0]   cfg_sid,
    input  logic [NUM_CAT-1:0] cfg_en_mask,
    input  logic               cfg_clr_seen,
    output logic               m_load_state,
    output logic               m_new_stream_id,
    output logic [SID_W-1:0]   m_stream_id,
    output logic [CHAR_W-1:0]  m_char_in,
    output logic               m_char_in_vld,
    output logic               m_eop,
    output logic [NUM_CAT-1:0] m_enable,
    input  logic [NUM_CAT-1:0] m_fired,
    output logic               res_vld,
    output logic [SID_W-1:0]   res_sid,
    output logic [NUM_CAT-1:0] res_hits,
    output logic [CNT_W-1:0]   pkt_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYC - 1);

    seq_state_e         state_q, state_d;
    logic [SID_W-1:0]   sid_q;
    logic [NUM_CAT-1:0] en_lat_q;
    logic               nsid_q;
    logic [2:0]         drain_q;
    logic [NUM_CAT-1:0] hits_q;
    logic [CNT_W-1:0]   pkt_cnt_q;
    logic [CNT_W-1:0]   drop_cnt_q;

    logic [NUM_CAT-1:0] tbl_en_mask;
    logic               tbl_seen;
    logic               sop_take;
    logic               drop_beat;

    dpi_stream_table #(
        .NUM_CAT (NUM_CAT)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_sid     (pkt_sid),
        .rd_en_mask (tbl_en_mask),
        .rd_seen    (tbl_seen),
        .wr_en      (cfg_we),
        .wr_sid     (cfg_sid),
        .wr_mask    (cfg_en_mask),
        .clr_en     (cfg_clr_seen),
        .clr_sid    (cfg_sid),
        .set_en     (state_q == ST_LOAD),
        .set_sid    (sid_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        pkt_rdy         = 1'b0;
        m_load_state    = 1'b0;
        m_new_stream_id = 1'b0;
        m_char_in       = '0;
        m_char_in_vld   = 1'b0;
        m_eop           = 1'b0;
        m_enable        = '0;
        res_vld         = 1'b0;
        res_sid         = '0;
        res_hits        = '0;
        sop_take        = 1'b0;
        drop_beat       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pkt_vld) begin
                    if (pkt_sop) begin
                        sop_take = 1'b1;
                        state_d  = ST_LOAD;
                    end else begin
                        pkt_rdy   = 1'b1;
                        drop_beat = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                m_load_state    = 1'b1;
                m_new_stream_id = nsid_q;
                state_d         = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                // The held SOP beat is still on the bus and becomes char 0.
                pkt_rdy       = 1'b1;
                m_char_in     = pkt_data;
                m_char_in_vld = pkt_vld;
                if (pkt_vld && pkt_eop) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = ST_EOP;
            end
            ST_EOP: begin
                m_eop    = 1'b1;
                m_enable = en_lat_q;
                state_d  = ST_REPORT;
            end
            ST_REPORT: begin
                res_vld  = 1'b1;
                res_sid  = sid_q;
                res_hits = hits_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-packet context. The enable mask is frozen at SOP so that table
    // writes during a packet only affect the next load of that stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sid_q    <= '0;
            en_lat_q <= '0;
            nsid_q   <= 1'b0;
        end else if (sop_take) begin
            sid_q    <= pkt_sid;
            en_lat_q <= tbl_en_mask;
            nsid_q   <= ~tbl_seen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drain_q <= '0;
        else        drain_q <= (state_q == ST_DRAIN) ? drain_q + 3'd1 : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                hits_q <= '0;
        else if (state_q == ST_EOP) hits_q <= m_fired & en_lat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (state_q == ST_REPORT) pkt_cnt_q  <= pkt_cnt_q + 16'd1;
            if (drop_beat)            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign m_stream_id = sid_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule : dpi_stream_sequencer

// File: tb/tb_dpi_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dpi_stream_sequencer
// Directed scenarios plus randomized packets/config against a stream-level
// model: seen flags and enable masks per sid, expected chars in exp_q, and
// packet/drop counts. Inputs change 1 time unit after posedge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dpi_stream_sequencer;
    import dpi_pkg::*;

    localparam int NUM_CAT   = 8;
    localparam int DRAIN_CYC = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               pkt_vld, pkt_rdy, pkt_sop, pkt_eop;
    logic [7:0]         pkt_data;
    logic [SID_W-1:0]   pkt_sid;
    logic               cfg_we, cfg_clr_seen;
    logic [SID_W-1:0]   cfg_sid;
    logic [NUM_CAT-1:0] cfg_en_mask;
    logic               m_load_state, m_new_stream_id, m_char_in_vld, m_eop;
    logic [SID_W-1:0]   m_stream_id;
    logic [7:0]         m_char_in;
    logic [NUM_CAT-1:0] m_enable, m_fired;
    logic               res_vld;
    logic [SID_W-1:0]   res_sid;
    logic [NUM_CAT-1:0] res_hits;
    logic [15:0]        pkt_cnt, drop_cnt;

    dpi_stream_sequencer #(
        .NUM_CAT   (NUM_CAT),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pkt_vld         (pkt_vld),
        .pkt_rdy         (pkt_rdy),
        .pkt_data        (pkt_data),
        .pkt_sop         (pkt_sop),
        .pkt_eop         (pkt_eop),
        .pkt_sid         (pkt_sid),
        .cfg_we          (cfg_we),
        .cfg_sid         (cfg_sid),
        .cfg_en_mask     (cfg_en_mask),
        .cfg_clr_seen    (cfg_clr_seen),
        .m_load_state    (m_load_state),
        .m_new_stream_id (m_new_stream_id),
        .m_stream_id     (m_stream_id),
        .m_char_in       (m_char_in),
        .m_char_in_vld   (m_char_in_vld),
        .m_eop           (m_eop),
        .m_enable        (m_enable),
        .m_fired         (m_fired),
        .res_vld         (res_vld),
        .res_sid         (res_sid),
        .res_hits        (res_hits),
        .pkt_cnt         (pkt_cnt),
        .drop_cnt        (drop_cnt)
    );

    // ---------------- scoreboard / model ----------------
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    bit         seen_m [NUM_STREAMS];
    logic [7:0] tbl_m  [NUM_STREAMS];
    int         pkt_m;
    int         drop_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_STREAMS; i++) begin
            seen_m[i] = 1'b0;
            tbl_m[i]  = '0;
        end
        pkt_m  = 0;
        drop_m = 0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {pkt_rdy, m_load_state, m_new_stream_id, m_char_in_vld, m_eop, res_vld}, 64'd0);
        check({tag, "_data"}, {m_stream_id, m_char_in, m_enable, res_sid, res_hits}, 64'd0);
        check({tag, "_cnt"}, {pkt_cnt, drop_cnt}, 64'd0);
    endtask

    task automatic cfg_op(input bit we, input bit clr, input logic [5:0] sid, input logic [7:0] mask);
        cfg_we       = we;
        cfg_clr_seen = clr;
        cfg_sid      = sid;
        cfg_en_mask  = mask;
        tick();
        cfg_we       = 1'b0;
        cfg_clr_seen = 1'b0;
        if (we)  tbl_m[sid]  = mask;
        if (clr) seen_m[sid] = 1'b0;
    endtask

    task automatic drop_beats(input int n);
        for (int i = 0; i < n; i++) begin
            pkt_vld  = 1'b1;
            pkt_sop  = 1'b0;
            pkt_eop  = 1'($urandom_range(0, 1));
            pkt_data = 8'($urandom);
            @(negedge clk);
            check("drop_rdy", pkt_rdy, 1);
            check("drop_no_char", {m_char_in_vld, m_load_state}, 0);
            tick();
            drop_m++;
        end
        pkt_vld = 1'b0;
        pkt_eop = 1'b0;
        check("drop_cnt", drop_cnt, 16'(drop_m));
    endtask

    // Sends one packet starting in IDLE and returns in IDLE (posedge+1).
    // mid_cfg writes mid_mask to this sid's table entry during beat 1;
    // clr_at_load clears this sid's seen bit during the LOAD cycle.
    task automatic send_pkt(input logic [5:0] sid, input int len, input logic [7:0] fired,
                            input bit mid_cfg, input logic [7:0] mid_mask, input bit clr_at_load);
        logic [7:0] exp_en;
        bit         exp_new;
        bit         got_eop;
        int         k;
        exp_new = !seen_m[sid];
        exp_en  = tbl_m[sid];
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(8'($urandom));
        m_fired  = fired;
        pkt_vld  = 1'b1;
        pkt_sop  = 1'b1;
        pkt_eop  = (len == 1);
        pkt_sid  = sid;
        pkt_data = exp_q[0];
        @(negedge clk);
        check("sop_held_rdy", pkt_rdy, 0);
        tick();
        if (clr_at_load) begin
            cfg_clr_seen = 1'b1;
            cfg_sid      = sid;
        end
        @(negedge clk);
        check("load_pulse", m_load_state, 1);
        check("load_new_sid", m_new_stream_id, exp_new);
        check("load_sid", m_stream_id, sid);
        check("load_no_char", m_char_in_vld, 0);
        tick();
        cfg_clr_seen = 1'b0;
        seen_m[sid]  = 1'b1;
        pkt_sid      = 6'($urandom);
        @(negedge clk);
        check("settle_quiet", {m_char_in_vld, m_load_state, pkt_rdy}, 0);
        tick();
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) begin
                    pkt_vld = 1'b0;
                    @(negedge clk);
                    check("gap_no_char", m_char_in_vld, 0);
                    tick();
                end
                pkt_vld  = 1'b1;
                pkt_sop  = ($urandom_range(0, 3) == 0);
                pkt_eop  = (i == len - 1);
                pkt_data = exp_q[0];
                pkt_sid  = 6'($urandom);
            end
            if (mid_cfg && i == 1) begin
                cfg_we      = 1'b1;
                cfg_sid     = sid;
                cfg_en_mask = mid_mask;
            end
            @(negedge clk);
            check("char_vld", m_char_in_vld, 1);
            check("char_rdy", pkt_rdy, 1);
            check("char", m_char_in, exp_q.pop_front());
            check("stream_sid", m_stream_id, sid);
            tick();
            if (mid_cfg && i == 1) begin
                cfg_we     = 1'b0;
                tbl_m[sid] = mid_mask;
            end
        end
        pkt_vld = 1'b0;
        pkt_sop = 1'b0;
        pkt_eop = 1'b0;
        got_eop = 1'b0;
        for (k = 1; k <= DRAIN_CYC + 4; k++) begin
            @(negedge clk);
            if (m_eop) begin
                got_eop = 1'b1;
                break;
            end
            check("drain_quiet", {pkt_rdy, m_char_in_vld, res_vld, m_enable}, 0);
            tick();
        end
        check("eop_delay", k, DRAIN_CYC + 1);
        if (got_eop) begin
            check("eop_enable", m_enable, exp_en);
            check("eop_sid", m_stream_id, sid);
            tick();
            @(negedge clk);
            check("res_vld", res_vld, 1);
            check("res_sid", res_sid, sid);
            check("res_hits", res_hits, fired & exp_en);
            check("res_eop_off", {m_eop, m_enable}, 0);
            tick();
            pkt_m++;
            check("pkt_cnt", pkt_cnt, 16'(pkt_m));
            check("res_once", res_vld, 0);
        end
    endtask

    // Starts a packet, then asserts reset while it is streaming.
    task automatic reset_mid(input logic [5:0] sid);
        m_fired  = '1;
        pkt_vld  = 1'b1;
        pkt_sop  = 1'b1;
        pkt_eop  = 1'b0;
        pkt_sid  = sid;
        pkt_data = 8'($urandom);
        repeat (3) tick();
        @(negedge clk);
        check("rm_char0", m_char_in_vld, 1);
        tick();
        pkt_sop  = 1'b0;
        pkt_data = 8'($urandom);
        @(negedge clk);
        check("rm_char1", m_char_in_vld, 1);
        #1;
        rst_n   = 1'b0;
        pkt_vld = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("rm_after_quiet", {m_load_state, m_eop, res_vld, m_char_in_vld}, 0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] rs;
    int         rlen;

    initial begin
        rst_n        = 1'b1;
        pkt_vld      = 1'b0;
        pkt_sop      = 1'b0;
        pkt_eop      = 1'b0;
        pkt_data     = '0;
        pkt_sid      = '0;
        cfg_we       = 1'b0;
        cfg_clr_seen = 1'b0;
        cfg_sid      = '0;
        cfg_en_mask  = '0;
        m_fired      = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        cfg_op(1'b1, 1'b0, 6'd5, 8'h03);
        send_pkt(6'd5, 4, 8'h01, 1'b0, 8'h00, 1'b0);
        send_pkt(6'd5, 3, 8'hFF, 1'b0, 8'h00, 1'b0);
        cfg_op(1'b0, 1'b1, 6'd5, 8'h00);
        send_pkt(6'd5, 2, 8'h02, 1'b0, 8'h00, 1'b0);
        send_pkt(6'd63, 1, 8'hA5, 1'b0, 8'h00, 1'b0);
        drop_beats(3);
        send_pkt(6'd7, 4, 8'hFF, 1'b1, 8'hFF, 1'b0);
        send_pkt(6'd7, 2, 8'h3C, 1'b0, 8'h00, 1'b0);
        send_pkt(6'd9, 2, 8'h0F, 1'b0, 8'h00, 1'b1);
        send_pkt(6'd9, 1, 8'h0F, 1'b0, 8'h00, 1'b0);
        cfg_op(1'b1, 1'b1, 6'd9, 8'h5A);
        send_pkt(6'd9, 3, 8'hFF, 1'b0, 8'h00, 1'b0);

        repeat (40) begin
            rs   = ($urandom_range(0, 4) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            rlen = $urandom_range(1, 6);
            case ($urandom_range(0, 5))
                0:       cfg_op(1'b1, 1'($urandom_range(0, 1)), rs, 8'($urandom));
                1:       cfg_op(1'b0, 1'b1, rs, 8'h00);
                2:       drop_beats($urandom_range(1, 2));
                default: send_pkt(rs, rlen, 8'($urandom), 1'($urandom_range(0, 1)),
                                  8'($urandom), ($urandom_range(0, 4) == 0));
            endcase
        end

        cfg_op(1'b1, 1'b0, 6'd11, 8'hC3);
        send_pkt(6'd11, 2, 8'hFF, 1'b0, 8'h00, 1'b0);
        reset_mid(6'd11);
        send_pkt(6'd11, 3, 8'hFF, 1'b0, 8'h00, 1'b0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_dpi_stream_sequencer
